// File: rtl/f32m_mult_arbiter_pkg.sv
// Shared definitions for the GF(3^{2M}) multiplier arbiter: element width,
// default timeout and FSM state encodings.
package f32m_mult_arbiter_pkg;

  // An element occupies W2+1 bits; W2 is sized for the configured field.
  localparam int W2          = 15;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/f32m_rr_pick.sv
// Combinational round-robin picker: the first requester found at or after
// ptr_i (wrapping) wins.
module f32m_rr_pick
  import f32m_mult_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Scan requesters starting at the pointer; keep the first hit.
  always_comb begin
    int  k;
    logic found;
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && (k < NREQ) && req_i[k]) begin
        found     = 1'b1;
        pick_o[k] = 1'b1;
        idx_o     = IW'(k);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/f32m_mult_arbiter.sv
// Shares one GF(3^{2M}) multiplier among NREQ requesters. Each granted
// operation latches operands, restarts the multiplier, waits for done (or a
// timeout) and returns the product with a one-cycle ack.
//
// state  | meaning
// IDLE   | multiplier held in restart, waiting for any request
// START  | one-cycle restart with the granted operands, counter cleared
// WAIT   | multiplier running; leave on done or on timeout
// RESP   | one-cycle ack (and err on timeout) to the granted requester
module f32m_mult_arbiter
  import f32m_mult_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*(W2+1)-1:0] a_in,
  input  logic [NREQ*(W2+1)-1:0] b_in,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic [W2:0]            result,
  output logic                   busy,
  output logic [W2:0]            m_a,
  output logic [W2:0]            m_b,
  output logic                   m_reset,
  input  logic [W2:0]            m_c,
  input  logic                   m_done
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [W2:0]     ma_q, ma_d, mb_q, mb_d, res_q, res_d;
  logic [W2:0]     ma_sel, mb_sel;
  logic            errf_q, errf_d;
  logic            mrst_q, mrst_d;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  f32m_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // State and datapath registers; m_reset is a flop so the restart is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      res_q   <= '0;
      errf_q  <= 1'b0;
      mrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      res_q   <= res_d;
      errf_q  <= errf_d;
      mrst_q  <= mrst_d;
    end
  end

  // Next state: grant, restart, wait for done/timeout, acknowledge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    res_d   = res_q;
    errf_d  = errf_q;
    ma_sel  = '0;
    mb_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        ma_sel = ma_sel | a_in[i*(W2+1) +: (W2+1)];
        mb_sel = mb_sel | b_in[i*(W2+1) +: (W2+1)];
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          ma_d    = ma_sel;
          mb_d    = mb_sel;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // done wins over a timeout landing in the same cycle
        if (m_done) begin
          res_d   = m_c;
          errf_d  = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          res_d   = '0;
          errf_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    mrst_d = (state_d != ST_WAIT);
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ack = '0;
    if (state_q == ST_RESP) ack[gnt_q] = 1'b1;
    err  = (state_q == ST_RESP) && errf_q;
    busy = (state_q != ST_IDLE);
  end

  assign result  = res_q;
  assign m_a     = ma_q;
  assign m_b     = mb_q;
  assign m_reset = mrst_q;

endmodule

// File: doc/f32m_mult_arbiter.md
# f32m_mult_arbiter

Shares one GF(3^{2M}) multiplier (`f32m_mult`) among `NREQ` requesters with round-robin arbitration. Each granted operation is sequenced as: latch operands, pulse the multiplier's restart, wait for its done flag, and return the product with a one-cycle acknowledge. The block sits between the pairing-core control units that need occasional GF(3^{2M}) products and the single multiplier instance, so no unit owns a dedicated multiplier.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1023: maximum WAIT cycles before the operation is aborted with an error.

Ports (all widths in `W2` come from the shared macros):
- `clk`  in  1  single clock; all flops on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester level request; hold high until the matching `ack` bit.
- `a_in`  in  NREQ*(W2+1)  operand A, slice i belongs to requester i.
- `b_in`  in  NREQ*(W2+1)  operand B, slice i belongs to requester i.
- `ack`  out  NREQ  one-hot, one-cycle pulse: result ready for that requester.
- `err`  out  1  pulses with `ack` when the operation timed out.
- `result`  out  W2+1  product, valid only in the `ack` cycle and held until the next RESP.
- `busy`  out  1  high in every state except IDLE.
- `m_a`, `m_b`  out  W2+1  registered operands driven to the multiplier.
- `m_reset`  out  1  active-high restart to the multiplier.
- `m_c`  in  W2+1  multiplier product.
- `m_done`  in  1  multiplier done flag; sticky until the next `m_reset`.

## Operation
- FSM states: IDLE, START, WAIT, RESP. Encodings are defined in the shared macro include.
- **IDLE**
  - `m_reset` = 1.
  - If any `req` bit is set: pick the winner round-robin, starting the search at `ptr`.
  - Latch the winner's `a_in`/`b_in` slices into `m_a`/`m_b`, record `gnt`, go to START.
- **START** (exactly 1 cycle)
  - `m_reset` = 1, so the multiplier restarts and clears its done flag.
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - `m_reset` = 0; the counter increments each cycle.
  - If `m_done` = 1: capture `m_c` into `result`, `err` = 0, go to RESP.
  - Else if the counter reaches `TIMEOUT`: `result` = 0, `err` = 1, go to RESP.
  - `m_done` takes precedence when both occur in the same cycle.
- **RESP** (exactly 1 cycle)
  - `ack[gnt]` = 1.
  - `ptr` ← (`gnt` + 1) mod `NREQ`; go to IDLE.
- Operands are frozen at grant. Requester inputs may change after the grant without effect on the running operation.
- A `req` that drops before its `ack` is a protocol error. The operation completes anyway and the ack is still issued.
- Requests arriving during START/WAIT/RESP are held off; they are considered at the next IDLE.
- The requester acked in RESP must drop `req` in the following cycle. If it is still high in IDLE, it is treated as a new request and loses priority to the others.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, `gnt` 0, counter 0.
  - `ack` 0, `err` 0, `busy` 0, `result` 0, `m_a`/`m_b` 0, `m_reset` 1.
- `m_reset` comes from a flop so it is glitch-free.
- Latency from a `req` sampled in IDLE to `ack` = 3 + Lm cycles, where Lm is the number of WAIT cycles until `m_done` = 1:
  - 1 cycle IDLE→START,
  - 1 cycle START,
  - Lm cycles WAIT,
  - 1 cycle RESP.
- Back-to-back operations: the next grant happens in the IDLE cycle immediately after RESP, so the minimum gap between grants is 3 + Lm cycles.
- Reset asserted mid-operation: all state is lost immediately, no `ack` is issued, `m_reset` goes to 1. Requesters must re-request after reset.
- Fairness: under full load every requester is served within `NREQ` operations.

## Structure
- Shared macro include holds the state encodings, the `W2` width, and the default `TIMEOUT`.
- One sub-module, `f32m_rr_pick`: a combinational round-robin picker.
  - Inputs: `req[NREQ-1:0]`, `ptr`.
  - Outputs: one-hot `pick`, its index, and `any`.
- The top level holds the FSM, operand/result registers, and the timeout counter.

## Test plan
- Only `req[2]` raised, with `a_in[2]` = 1 and `b_in[2]` = 1 (the GF(3^{2M}) unit), multiplier model with Lm = 40 → `m_reset` low for 40 cycles, `ack` = 4'b0100 at cycle 43, `result` = 1, `err` = 0.
- `req` = 4'b1111 held continuously from reset → grants in order 0,1,2,3,0, and each result matches the reference product for its operands.
- `ptr` = 3 and `req` = 4'b1001 → requester 3 served first, then 0.
- `m_done` held at 0 with `TIMEOUT` = 15 → `ack` plus `err` = 1 and `result` = 0 exactly 18 cycles after the request; the next request then succeeds normally.
- `reset_n` pulsed low during WAIT → outputs return to their reset values asynchronously; no `ack` is issued; a following request completes.
- `a_in[1]` changed the cycle after grant → `result` still equals the product of the operands latched at grant.
